ahb_sram_slave: RTL

AHB subordinate (responder) that terminates one slave port of the AHB interconnect and backs it with a word-organised register-array memory. Decodes address/control from the interconnect, inserts a programmable number of wait states, performs byte/halfword/word reads and writes, and returns a two-cycle ERROR response for illegal accesses. Serves as the standard memory target for interconnect bring-up and system simulation.

---
 rtl/ahb_sram_slave.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ahb_sram_slave.sv
// AHB subordinate backed by a word-organised register array.
// Programmable wait states, byte/halfword/word lanes and a two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 25,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                  i_hclk,
    input  logic                  i_hreset,
    input  logic                  i_hsel,
    input  logic                  i_hready_in,
    input  logic [ADDR_WIDTH-1:0] i_haddr,
    input  logic [1:0]            i_htrans,
    input  logic                  i_hwrite,
    input  logic [2:0]            i_hburst,
    input  logic [3:0]            i_hsize,
    input  logic [DATA_WIDTH-1:0] i_hwdata,
    output logic [DATA_WIDTH-1:0] o_hrdata,
    output logic                  o_hready,
    output logic                  o_hresp
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    // IDLE no transfer | WAIT inserting waits | DONE okay completes | ERR1/ERR2 error cycles
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [1:0]            r_lane;
    logic [1:0]            r_size;
    logic                  r_write;
    logic                  r_hready;
    logic                  r_hresp;
    logic [DATA_WIDTH-1:0] r_hrdata;

    logic                  w_accept;
    logic                  w_illegal;
    logic                  w_commit;
    logic                  w_bypass;
    logic [IDX_W-1:0]      w_idx;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_merged;
    logic                  w_unused;

    assign w_accept  = i_hsel & i_hready_in & i_htrans[1] &
                       ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR2));
    assign w_idx     = i_haddr[IDX_W+1:2];
    assign w_illegal = (|i_haddr[ADDR_WIDTH-1:IDX_W+2]) |
                       (i_hsize > 4'd2) |
                       ((i_hsize == 4'd1) & i_haddr[0]) |
                       ((i_hsize == 4'd2) & (i_haddr[1:0] != 2'b00));
    assign w_commit  = (r_state == S_DONE) & r_write;
    assign w_bypass  = w_commit & (r_idx == w_idx);
    assign w_unused  = ^{i_htrans[0], i_hburst};

    always_comb begin
        w_be = 4'b1111;
        case (r_size)
            2'd0:    w_be = 4'b0001 << r_lane;
            2'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
        w_merged = r_mem[r_idx];
        for (int b = 0; b < 4; b++) begin
            if (w_be[b]) w_merged[8*b +: 8] = i_hwdata[8*b +: 8];
        end
    end

    // Array is not reset; writes happen only on the edge that ends an OKAY write.
    always_ff @(posedge i_hclk) begin
        if (w_commit) r_mem[r_idx] <= w_merged;
    end

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_lane   <= '0;
            r_size   <= '0;
            r_write  <= 1'b0;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
            r_hrdata <= '0;
        end else if (w_accept) begin
            r_idx   <= w_idx;
            r_lane  <= i_haddr[1:0];
            r_size  <= i_hsize[1:0];
            r_write <= i_hwrite;
            if (w_illegal) begin
                r_state  <= S_ERR1;
                r_hready <= 1'b0;
                r_hresp  <= 1'b1;
            end else begin
                // A read landing on the word being committed this edge sees the merged data.
                if (!i_hwrite) r_hrdata <= w_bypass ? w_merged : r_mem[w_idx];
                r_hresp <= 1'b0;
                if (WAIT_STATES > 0) begin
                    r_state  <= S_WAIT;
                    r_cnt    <= 4'(WAIT_STATES - 1);
                    r_hready <= 1'b0;
                end else begin
                    r_state  <= S_DONE;
                    r_hready <= 1'b1;
                end
            end
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state  <= S_DONE;
                        r_hready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    r_state  <= S_ERR2;
                    r_hready <= 1'b1;
                    r_hresp  <= 1'b1;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_hready <= 1'b1;
                    r_hresp  <= 1'b0;
                end
            endcase
        end
    end

    assign o_hrdata = r_hrdata;
    assign o_hready = r_hready;
    assign o_hresp  = r_hresp;
endmodule
